data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 118 +++++++++++
 tb/tb_data_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder: fronts a synchronous RAM, an LED register
// and a read-only ID word behind a single request/ack handshake.
module data_mem_responder #(
    parameter int unsigned RAM_AW = 8,
    parameter logic [31:0] LED_ID = 32'h41524D33
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr_en,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wren,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [9:0]        led_out
);

    localparam logic [31:0] RAM_WORDS = 32'(1) << RAM_AW;
    localparam logic [31:0] LED_ADDR  = 32'd256;
    localparam logic [31:0] ID_ADDR   = 32'd257;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    typedef enum logic [1:0] {TGT_RAM, TGT_LED, TGT_ID, TGT_NONE} target_t;

    function automatic target_t decode(input logic [31:0] a);
        if (a < RAM_WORDS)     return TGT_RAM;
        else if (a == LED_ADDR) return TGT_LED;
        else if (a == ID_ADDR)  return TGT_ID;
        else                    return TGT_NONE;
    endfunction

    // The ID word is read-only, so a store to it is flagged like an unmapped access.
    function automatic logic access_err(input target_t t, input logic wr);
        return (t == TGT_NONE) || (wr && (t == TGT_ID));
    endfunction

    state_t      state, state_next;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic        wr_p0;
    target_t     tgt_p0;

    assign tgt_p0 = decode(addr_p0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Stage p0: request captured on the accepting edge, held for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p0  <= '0;
            wdata_p0 <= '0;
            wr_p0    <= 1'b0;
        end else if (state == IDLE && req) begin
            addr_p0  <= addr;
            wdata_p0 <= wdata;
            wr_p0    <= wr_en;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        ack        = 1'b0;
        err        = 1'b0;
        ram_wren   = 1'b0;
        ram_addr   = addr_p0[RAM_AW-1:0];
        ram_din    = wdata_p0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req) state_next = ACCESS;
            end
            ACCESS: begin
                ram_wren   = wr_p0 && (tgt_p0 == TGT_RAM);
                state_next = wr_p0 ? RESP : WAIT;
            end
            WAIT: state_next = RESP;
            RESP: begin
                ack        = 1'b1;
                err        = access_err(tgt_p0, wr_p0);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p1: load data captured in WAIT, when the RAM output is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (state == WAIT) begin
            case (tgt_p0)
                TGT_RAM: rdata <= ram_dout;
                TGT_LED: rdata <= {22'd0, led_out};
                TGT_ID:  rdata <= LED_ID;
                default: rdata <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out <= '0;
        end else if (state == ACCESS && wr_p0 && tgt_p0 == TGT_LED) begin
            led_out <= wdata_p0[9:0];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed scenarios plus random traffic
// against an address-map reference model with a behavioural RAM attached.
module tb_data_mem_responder;

    localparam logic [31:0] ID_WORD = 32'h41524D33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic [9:0]  led_out;

    data_mem_responder #(.RAM_AW(8), .LED_ID(ID_WORD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy), .ram_addr(ram_addr),
        .ram_wren(ram_wren), .ram_din(ram_din), .ram_dout(ram_dout), .led_out(led_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // Behavioural synchronous RAM with one-cycle read latency
    logic [31:0] ram [256];
    logic        ram_fill = 1'b1;
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (ram_wren) begin
            ram[ram_addr] <= ram_din;
        end
        ram_dout <= ram[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [9:0]  led;
    } resp_t;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    resp_t exp_q[$];
    wr_t   wr_q[$];
    int    checks = 0;
    int    failures = 0;

    logic [31:0] ref_mem [256];
    logic [9:0]  ref_led;
    logic [31:0] ref_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the address map to one access and queues the expected response
    task automatic model_issue(input bit wr, input logic [31:0] a, input logic [31:0] d);
        resp_t r;
        wr_t   w;
        r.err = 1'b0;
        if (wr) begin
            if (a < 256) begin
                ref_mem[a[7:0]] = d;
                w.a = a[7:0];
                w.d = d;
                wr_q.push_back(w);
            end else if (a == 256) begin
                ref_led = d[9:0];
            end else begin
                r.err = 1'b1;
            end
        end else begin
            if (a < 256)       ref_rdata = ref_mem[a[7:0]];
            else if (a == 256) ref_rdata = {22'd0, ref_led};
            else if (a == 257) ref_rdata = ID_WORD;
            else begin
                ref_rdata = '0;
                r.err = 1'b1;
            end
        end
        r.rdata = ref_rdata;
        r.led   = ref_led;
        exp_q.push_back(r);
    endtask

    // Monitor: pops expectations whenever the DUT acks or writes the RAM
    initial begin
        resp_t r;
        wr_t   w;
        forever begin
            @(negedge clk);
            if (ack) begin
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    check("rdata", rdata, r.rdata);
                    check("err", 32'(err), 32'(r.err));
                    check("led_out", 32'(led_out), 32'(r.led));
                end
            end
            if (ram_wren) begin
                if (wr_q.size() == 0) begin
                    check("ram_wren_unexpected", 32'(ram_wren), 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("ram_addr_wr", 32'(ram_addr), 32'(w.a));
                    check("ram_din", ram_din, w.d);
                end
            end
        end
    end

    // Latency is counted in rising edges from the accepting edge to the edge at which ack is sampled high.
    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int t_acc;
        bit got;
        model_issue(wr, a, d);
        req = 1'b1; wr_en = wr; addr = a; wdata = d;
        @(posedge clk); #1;
        t_acc = cyc;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        req = 1'b0; wr_en = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        else check(wr ? "store_latency" : "load_latency", 32'(cyc + 1 - t_acc), wr ? 32'd2 : 32'd3);
        @(negedge clk);
    endtask

    // req held high through a store while the bus changes to a load mid-access
    task automatic b2b(input logic [31:0] a1, input logic [31:0] d1, input logic [31:0] a2);
        int t_acc, c1, c2;
        bit got;
        model_issue(1'b1, a1, d1);
        model_issue(1'b0, a2, 32'd0);
        req = 1'b1; wr_en = 1'b1; addr = a1; wdata = d1;
        @(posedge clk); #1;
        t_acc = cyc;
        @(negedge clk);
        wr_en = 1'b0; addr = a2; wdata = $urandom;
        got = 1'b0; c1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1; c1 = cyc;
                break;
            end
        end
        if (!got) check("b2b_ack1_timeout", 32'd0, 32'd1);
        else check("b2b_store_latency", 32'(c1 + 1 - t_acc), 32'd2);
        got = 1'b0; c2 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1; c2 = cyc;
                break;
            end
        end
        req = 1'b0;
        if (!got) check("b2b_ack2_timeout", 32'd0, 32'd1);
        else check("b2b_ack_gap", 32'(c2 - c1), 32'd4);
        @(negedge clk);
    endtask

    // Accept an access, then assert reset k cycles into it (k=0: ACCESS, k=1: second busy cycle)
    task automatic abort_op(input bit wr, input logic [31:0] a, input logic [31:0] d, input int k);
        req = 1'b1; wr_en = wr; addr = a; wdata = d;
        @(posedge clk);
        repeat (k) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_ram_wren", 32'(ram_wren), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_led_out", 32'(led_out), 32'd0);
        check("abort_ram_addr", 32'(ram_addr), 32'd0);
        req = 1'b0;
        ref_led = '0;
        ref_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        bit          wr;
        int          sel;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        ref_led = '0;
        ref_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ram_wren", 32'(ram_wren), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_led_out", 32'(led_out), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        rst_n = 1'b1;
        ram_fill = 1'b0;

        do_access(1'b1, 32'd10, 32'd11);
        do_access(1'b0, 32'd10, 32'd0);
        do_access(1'b1, 32'd256, 32'h3FF);
        check("led_after_store", 32'(led_out), 32'h3FF);
        do_access(1'b0, 32'd256, 32'd0);
        do_access(1'b0, 32'd257, 32'd0);
        do_access(1'b1, 32'd257, 32'h1234_5678);
        do_access(1'b0, 32'd257, 32'd0);
        do_access(1'b0, 32'd300, 32'd0);
        do_access(1'b1, 32'd300, 32'hCAFE_F00D);
        do_access(1'b0, 32'd255, 32'd0);
        do_access(1'b1, 32'd255, 32'h5555_AAAA);
        do_access(1'b0, 32'd255, 32'd0);
        do_access(1'b0, 32'd258, 32'd0);
        do_access(1'b0, 32'hFFFF_FFFF, 32'd0);
        b2b(32'd20, 32'hB2B0_0001, 32'd20);

        abort_op(1'b0, 32'd10, 32'd0, 1);
        do_access(1'b0, 32'd10, 32'd0);
        do_access(1'b0, 32'd256, 32'd0);
        abort_op(1'b1, 32'd12, 32'hDEAD_BEEF, 0);
        do_access(1'b0, 32'd12, 32'd0);

        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 9));
            wr = 1'($urandom_range(0, 1));
            if (sel <= 5)      a = $urandom_range(0, 31);
            else if (sel == 6) a = 32'd256;
            else if (sel == 7) a = 32'd257;
            else if (sel == 8) a = $urandom_range(258, 1000);
            else               a = $urandom;
            do_access(wr, a, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
